fabric_config_ctrl: RTL
=======================

Name: fabric_config_ctrl

Overview:
Parametrised configuration controller for a multi-cluster tinyFPGA fabric. It replaces the single raw shift chain with a framed serial protocol that addresses one of NUM_CHAINS cluster configuration chains, and loads it with parity checking. It also supports non-destructive readback and a commit command that releases the fabric. It sits between the pin-level programming interface and the per-cluster config shift registers, all on the fabric clock.

Parameters:
NUM_CHAINS, 4, number of independent cluster config chains (1..64)
CHAIN_LEN, 64, config bits per chain (>=2)

Ports:
clk  input  1  fabric clock; all logic rising-edge
rst_n  input  1  asynchronous active-low reset
prog_en  input  1  session enable; low aborts any frame
prog_valid  input  1  prog_in carries a valid bit this cycle
prog_in  input  1  serial frame data, MSB-first
prog_out  output  1  readback data bit
prog_out_valid  output  1  prog_out valid this cycle
chain_shift  output  NUM_CHAINS  one-hot shift enable, one bit per chain
chain_din  output  1  bit shifted into the tail of the enabled chain
chain_dout  input  NUM_CHAINS  head (last) bit of each chain
busy  output  1  high in any state except IDLE
cfg_done  output  1  fabric configured and released
cfg_err  output  1  sticky protocol/parity error

Behaviour:
- Reset (rst_n low, async): state IDLE. All outputs are 0. Written-mask, counters and parity are cleared.
- Frame header: 8 bits, MSB-first, accepted only when prog_en & prog_valid.
  - hdr[7:6] = cmd: 01 write, 10 readback, 11 commit, 00 illegal.
  - hdr[5:0] = chain index.
- States: IDLE, HDR, WR, PAR, RD, RDPAR, ERR.
- IDLE -> HDR:
  - Taken on the first accepted bit; that bit is header bit 7.
  - A prog_en rising edge (registered) clears cfg_err.
- HDR, after the 8th bit:
  - cmd 00, or index >= NUM_CHAINS for write/readback: go to ERR and set cfg_err.
  - write: go to WR, clear cfg_done, clear written_mask[idx].
  - readback: go to RD.
  - commit: if written_mask is all ones, set cfg_done; else set cfg_err. Then go to IDLE. The commit index is ignored.
- WR:
  - Each accepted bit produces a registered one-cycle pulse on chain_shift[idx], with chain_din = that bit. Latency is exactly 1 cycle.
  - Running even parity is accumulated.
  - After CHAIN_LEN bits, go to PAR.
  - Gaps in prog_valid stall the controller; no pulses are issued during gaps.
- PAR:
  - The next accepted bit is the parity bit; even parity over data plus parity bit must be 0.
  - Pass: set written_mask[idx]. Fail: set cfg_err, leave the mask bit clear.
  - Go to IDLE in either case.
- RD:
  - prog_valid is ignored; the controller runs autonomously for CHAIN_LEN consecutive cycles.
  - Each cycle: chain_shift[idx] = 1, chain_din = chain_dout[idx] (rotate), prog_out = chain_dout[idx], prog_out_valid = 1.
  - Chain contents are unchanged after CHAIN_LEN rotations.
  - Parity is accumulated over the bits presented.
- RDPAR: one cycle with prog_out = accumulated even parity and prog_out_valid = 1, then IDLE.
- ERR: all input is ignored until prog_en is low, then IDLE. cfg_err stays 1.
- prog_en low in any non-IDLE state: go to IDLE on the next clock. Counters and parity clear, outputs go low.
  - If the abort happens in WR/PAR, written_mask[idx] stays clear.
  - A pulse already registered still completes; no further pulses are issued.
- cfg_done: cleared by reset or by a write header; unaffected by readback or abort.
- Bit counter width is clog2(CHAIN_LEN+1). The counter resets to 0 on entry to WR and RD and never wraps within a frame.
- Simultaneous events: when prog_en falls in the same cycle as the final PAR bit, the abort wins and the mask bit is not set.

Test Plan:
- Reset mid-WR (rst_n low at bit 20) -> all outputs 0 immediately (async). Next frame parses normally.
- Write chain 2 with 0xA5 repeated x8, parity 0 -> 64 single-cycle chain_shift = 4'b0100 pulses, each 1 cycle after its accepted bit, chain_din matching. cfg_err = 0.
- Write chain 0 with wrong parity, then commit 0xC0 -> cfg_err = 1, cfg_done = 0.
- Write chains 0..3 correctly with random gaps in prog_valid, then 0xC0 -> cfg_done = 1 the cycle after the 8th commit bit; busy = 0 in that cycle.
- Readback chain 1 (header 0x81) after a load -> 65 consecutive prog_out_valid cycles: 64 data bits equal to the loaded bits MSB-first, then the parity bit. A second readback returns identical data.
- Header 0x45 (write, index 5): cfg_err = 1, ERR state until prog_en drops. prog_en drop after 10 data bits of a valid write -> IDLE and busy = 0 next clock, no further chain_shift pulses.

Source files
------------

// File: rtl/fabric_config_ctrl.sv
// Framed serial configuration controller for a multi-cluster fabric: addressed
// chain load with parity, non-destructive readback and a commit that releases the fabric.
module fabric_config_ctrl #(
  parameter int unsigned NUM_CHAINS = 4,
  parameter int unsigned CHAIN_LEN  = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  prog_en,
  input  logic                  prog_valid,
  input  logic                  prog_in,
  output logic                  prog_out,
  output logic                  prog_out_valid,
  output logic [NUM_CHAINS-1:0] chain_shift,
  output logic                  chain_din,
  input  logic [NUM_CHAINS-1:0] chain_dout,
  output logic                  busy,
  output logic                  cfg_done,
  output logic                  cfg_err
);

  localparam int unsigned IW = (NUM_CHAINS > 1) ? $clog2(NUM_CHAINS) : 1;
  localparam int unsigned CW = $clog2(CHAIN_LEN + 1);

  typedef enum logic [2:0] {IDLE, HDR, WR, PAR, RD, RDPAR, ERR} state_t;

  state_t                state;
  logic [6:0]            hdr_sr;
  logic [2:0]            hdr_cnt;
  logic [IW-1:0]         idx;
  logic [CW-1:0]         bit_cnt;
  logic                  parity;
  logic [NUM_CHAINS-1:0] written_mask;
  logic [NUM_CHAINS-1:0] wr_shift;
  logic                  wr_din;
  logic                  par_out;
  logic                  par_valid;
  logic                  prog_en_q;

  logic                  accept;
  logic [7:0]            hdr_full;
  logic                  idx_ok;
  logic [NUM_CHAINS-1:0] idx_onehot;
  logic                  rd_active;
  logic                  head;

  assign accept     = prog_en & prog_valid;
  assign hdr_full   = {hdr_sr, prog_in};
  assign idx_ok     = {1'b0, hdr_full[5:0]} < 7'(NUM_CHAINS);
  assign idx_onehot = NUM_CHAINS'(1) << idx;
  assign head       = chain_dout[idx];

  // Readback rotation is driven straight from the chain head in the same cycle;
  // a registered pulse would sample the head before the previous shift lands.
  assign rd_active      = (state == RD) & prog_en;
  assign chain_shift    = wr_shift | (rd_active ? idx_onehot : '0);
  assign chain_din      = rd_active ? head : wr_din;
  assign prog_out       = rd_active ? head : par_out;
  assign prog_out_valid = rd_active | par_valid;
  assign busy           = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      hdr_sr       <= '0;
      hdr_cnt      <= '0;
      idx          <= '0;
      bit_cnt      <= '0;
      parity       <= 1'b0;
      written_mask <= '0;
      wr_shift     <= '0;
      wr_din       <= 1'b0;
      par_out      <= 1'b0;
      par_valid    <= 1'b0;
      prog_en_q    <= 1'b0;
      cfg_done     <= 1'b0;
      cfg_err      <= 1'b0;
    end else begin
      prog_en_q <= prog_en;
      wr_shift  <= '0;
      wr_din    <= 1'b0;
      par_out   <= 1'b0;
      par_valid <= 1'b0;
      if (state != IDLE && !prog_en) begin
        state   <= IDLE;
        hdr_cnt <= '0;
        bit_cnt <= '0;
        parity  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (prog_en && !prog_en_q) cfg_err <= 1'b0;
            if (accept) begin
              hdr_sr  <= {6'b0, prog_in};
              hdr_cnt <= 3'd1;
              state   <= HDR;
            end
          end
          HDR: if (accept) begin
            if (hdr_cnt != 3'd7) begin
              hdr_sr  <= {hdr_sr[5:0], prog_in};
              hdr_cnt <= hdr_cnt + 3'd1;
            end else begin
              hdr_cnt <= '0;
              bit_cnt <= '0;
              parity  <= 1'b0;
              case (hdr_full[7:6])
                2'b01: if (idx_ok) begin
                  idx                            <= hdr_full[IW-1:0];
                  written_mask[hdr_full[IW-1:0]] <= 1'b0;
                  cfg_done                       <= 1'b0;
                  state                          <= WR;
                end else begin
                  cfg_err <= 1'b1;
                  state   <= ERR;
                end
                2'b10: if (idx_ok) begin
                  idx   <= hdr_full[IW-1:0];
                  state <= RD;
                end else begin
                  cfg_err <= 1'b1;
                  state   <= ERR;
                end
                2'b11: begin
                  if (&written_mask) cfg_done <= 1'b1;
                  else               cfg_err  <= 1'b1;
                  state <= IDLE;
                end
                default: begin
                  cfg_err <= 1'b1;
                  state   <= ERR;
                end
              endcase
            end
          end
          WR: if (accept) begin
            wr_shift <= idx_onehot;
            wr_din   <= prog_in;
            parity   <= parity ^ prog_in;
            bit_cnt  <= bit_cnt + 1'b1;
            if (bit_cnt == CW'(CHAIN_LEN - 1)) state <= PAR;
          end
          PAR: if (accept) begin
            if (parity ^ prog_in) cfg_err           <= 1'b1;
            else                  written_mask[idx] <= 1'b1;
            parity  <= 1'b0;
            bit_cnt <= '0;
            state   <= IDLE;
          end
          RD: begin
            parity  <= parity ^ head;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == CW'(CHAIN_LEN - 1)) begin
              par_out   <= parity ^ head;
              par_valid <= 1'b1;
              state     <= RDPAR;
            end
          end
          RDPAR: begin
            parity  <= 1'b0;
            bit_cnt <= '0;
            state   <= IDLE;
          end
          ERR:     state <= ERR;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
